// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: opcode constants,
// opcode classes, FSM state encoding and ALU control width.
package multicycle_control_pkg;

    localparam int ALU_W = 5;

    localparam logic [5:0] OP_ANDR = 6'b100000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_JR   = 6'b001000;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_NORR = 6'b100110;
    localparam logic [5:0] OP_NORI = 6'b001110;
    localparam logic [5:0] OP_NOTR = 6'b000100;
    localparam logic [5:0] OP_BLEU = 6'b010000;
    localparam logic [5:0] OP_ROLV = 6'b000000;
    localparam logic [5:0] OP_RORV = 6'b000010;

    // Encodings 5..7 are unused and recover to FETCH.
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    // CLS_RI is the immediate-operand member of the R-class (nori):
    // it writes back like the others but selects the immediate ALU source.
    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_R       = 3'd1,
        CLS_RI      = 3'd2,
        CLS_LW      = 3'd3,
        CLS_SW      = 3'd4,
        CLS_BLEU    = 3'd5,
        CLS_JR      = 3'd6,
        CLS_JAL     = 3'd7
    } opclass_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle.
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [31:0]      ins;
    logic             memReady;
    logic             memReq;
    logic             iorD;
    logic             irWrite;
    logic             pcWrite;
    logic             memWrite;
    logic             memToReg;
    logic             regDst;
    logic             ALUSrc;
    logic             branchEnable;
    logic             jump;
    logic             regWriteEnable;
    logic [ALU_W-1:0] ALUControl;
    logic             illegal;
    logic [2:0]       state;

    modport master (
        input  ins, memReady,
        output memReq, iorD, irWrite, pcWrite, memWrite, memToReg, regDst,
               ALUSrc, branchEnable, jump, regWriteEnable, ALUControl,
               illegal, state
    );

    modport slave (
        output ins, memReady,
        input  memReq, iorD, irWrite, pcWrite, memWrite, memToReg, regDst,
               ALUSrc, branchEnable, jump, regWriteEnable, ALUControl,
               illegal, state
    );

endinterface

// File: rtl/multicycle_control_opcode_decode.sv
// Purely combinational opcode classifier.
module opcode_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0] opcode,
    output opclass_t   opclass,
    output logic       legal
);

    // Map the 6-bit opcode onto its execution class
    always_comb begin
        opclass = CLS_ILLEGAL;
        case (opcode)
            OP_ANDR, OP_NORR, OP_NOTR, OP_ROLV, OP_RORV: opclass = CLS_R;
            OP_NORI: opclass = CLS_RI;
            OP_LW:   opclass = CLS_LW;
            OP_SW:   opclass = CLS_SW;
            OP_BLEU: opclass = CLS_BLEU;
            OP_JR:   opclass = CLS_JR;
            OP_JAL:  opclass = CLS_JAL;
            default: opclass = CLS_ILLEGAL;
        endcase
        legal = (opclass != CLS_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t           state_q;
    state_t           state_d;
    opclass_t         cls_q;
    opclass_t         dec_cls;
    logic             dec_legal;
    logic [ALU_W-1:0] alu_q;

    opcode_decode u_decode (
        .opcode  (bus.ins[31:26]),
        .opclass (dec_cls),
        .legal   (dec_legal)
    );

    // State register; reset parks the FSM in FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Capture class and ALU code only in DECODE so ins is ignored elsewhere
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cls_q <= CLS_ILLEGAL;
            alu_q <= '0;
        end else if (state_q == DECODE) begin
            cls_q <= dec_cls;
            alu_q <= bus.ins[31:27];
        end
    end

    assign bus.ALUControl = alu_q;
    assign bus.state      = state_q;

    // Next-state and control outputs; everything is forced low during reset
    always_comb begin
        state_d            = FETCH;
        bus.memReq         = 1'b0;
        bus.iorD           = 1'b0;
        bus.irWrite        = 1'b0;
        bus.pcWrite        = 1'b0;
        bus.memWrite       = 1'b0;
        bus.memToReg       = 1'b0;
        bus.regDst         = 1'b0;
        bus.ALUSrc         = 1'b0;
        bus.branchEnable   = 1'b0;
        bus.jump           = 1'b0;
        bus.regWriteEnable = 1'b0;
        bus.illegal        = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    bus.memReq = 1'b1;
                    if (bus.memReady) begin
                        bus.irWrite = 1'b1;
                        bus.pcWrite = 1'b1;
                        state_d     = DECODE;
                    end else begin
                        state_d = FETCH;
                    end
                end
                DECODE: begin
                    if (dec_legal) state_d = EXEC;
                    else begin
                        bus.illegal = 1'b1;
                        state_d     = FETCH;
                    end
                end
                EXEC: begin
                    bus.ALUSrc = (cls_q == CLS_RI) || (cls_q == CLS_LW) || (cls_q == CLS_SW);
                    case (cls_q)
                        CLS_R, CLS_RI:  state_d = WB;
                        CLS_LW, CLS_SW: state_d = MEM;
                        CLS_BLEU:       bus.branchEnable = 1'b1;
                        CLS_JR:         bus.jump = 1'b1;
                        CLS_JAL: begin
                            bus.jump           = 1'b1;
                            bus.regWriteEnable = 1'b1;
                        end
                        default:        state_d = FETCH;
                    endcase
                end
                MEM: begin
                    bus.memReq   = 1'b1;
                    bus.iorD     = 1'b1;
                    bus.memWrite = (cls_q == CLS_SW);
                    if (bus.memReady) state_d = (cls_q == CLS_LW) ? WB : FETCH;
                    else              state_d = MEM;
                end
                WB: begin
                    bus.regWriteEnable = 1'b1;
                    bus.regDst         = (cls_q == CLS_R) || (cls_q == CLS_RI);
                    bus.memToReg       = (cls_q == CLS_LW);
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset = 1'b1;
    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Output vector layout: {state[2:0], ALUControl[4:0], flags[11:0]}
    localparam logic [11:0] MREQ = 12'h001, IORD = 12'h002, IRW  = 12'h004, PCW = 12'h008;
    localparam logic [11:0] MW   = 12'h010, M2R  = 12'h020, RDST = 12'h040, ASRC = 12'h080;
    localparam logic [11:0] BR   = 12'h100, JMP  = 12'h200, RWE  = 12'h400, ILL = 12'h800;

    typedef struct {
        logic [31:0] ins;
        logic        rdy;
        logic        rst;
        logic [19:0] expv;
        string       tag;
    } cyc_t;

    cyc_t        plan[$];
    logic [19:0] sb[$];
    string       sb_tag[$];
    logic [4:0]  alu_hold;
    int          checks = 0;
    int          errors = 0;
    int          cycle_no = 0;

    function automatic logic [19:0] ev(input logic [2:0] st, input logic [4:0] alu, input logic [11:0] f);
        return {st, alu, f};
    endfunction

    function automatic cyc_t mk(input logic [31:0] i, input logic r, input logic rs,
                                input logic [19:0] e, input string t);
        cyc_t c;
        c.ins = i; c.rdy = r; c.rst = rs; c.expv = e; c.tag = t;
        return c;
    endfunction

    // Instruction kinds straight from the opcode table
    function automatic string kind_of(input logic [5:0] op);
        case (op)
            6'b100000, 6'b100110, 6'b000100, 6'b000000, 6'b000010: return "alu";
            6'b001110: return "alui";
            6'b100011: return "lw";
            6'b101011: return "sw";
            6'b010000: return "bleu";
            6'b001000: return "jr";
            6'b000011: return "jal";
            default:   return "bad";
        endcase
    endfunction

    function automatic logic [31:0] rnd32();
        return $urandom;
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add_reset(input int n);
        for (int i = 0; i < n; i++)
            plan.push_back(mk(rnd32(), rnd1(), 1'b1, 20'h0, "reset"));
        alu_hold = 5'd0;
    endtask

    // Build the expected cycle sequence for one instruction.
    // wf/wm: wait cycles before memReady in FETCH/MEM; abort_at>=0 cuts the
    // instruction after that many cycles and applies a reset instead.
    task automatic add_instr(input logic [31:0] ins, input int wf, input int wm, input int abort_at);
        cyc_t        tmp[$];
        string       k;
        logic [4:0]  a_new;
        logic [11:0] f;
        k     = kind_of(ins[31:26]);
        a_new = ins[31:27];
        for (int i = 0; i < wf; i++)
            tmp.push_back(mk(rnd32(), 1'b0, 1'b0, ev(3'd0, alu_hold, MREQ), "fetch_wait"));
        tmp.push_back(mk(rnd32(), 1'b1, 1'b0, ev(3'd0, alu_hold, MREQ | IRW | PCW), "fetch_done"));
        tmp.push_back(mk(ins, rnd1(), 1'b0, ev(3'd1, alu_hold, (k == "bad") ? ILL : 12'h0), "decode"));
        if (k != "bad") begin
            f = 12'h0;
            if (k == "alui" || k == "lw" || k == "sw") f = f | ASRC;
            if (k == "bleu") f = f | BR;
            if (k == "jr")   f = f | JMP;
            if (k == "jal")  f = f | JMP | RWE;
            tmp.push_back(mk(rnd32(), rnd1(), 1'b0, ev(3'd2, a_new, f), "exec"));
            if (k == "lw" || k == "sw") begin
                f = MREQ | IORD | ((k == "sw") ? MW : 12'h0);
                for (int i = 0; i < wm; i++)
                    tmp.push_back(mk(rnd32(), 1'b0, 1'b0, ev(3'd3, a_new, f), "mem_wait"));
                tmp.push_back(mk(rnd32(), 1'b1, 1'b0, ev(3'd3, a_new, f), "mem_done"));
            end
            if (k == "alu" || k == "alui" || k == "lw")
                tmp.push_back(mk(rnd32(), rnd1(), 1'b0,
                                 ev(3'd4, a_new, RWE | ((k == "lw") ? M2R : RDST)), "wb"));
        end
        if (abort_at >= 0 && abort_at < tmp.size()) begin
            while (tmp.size() > abort_at) void'(tmp.pop_back());
            foreach (tmp[i]) plan.push_back(tmp[i]);
            add_reset(1 + int'($urandom_range(0, 1)));
        end else begin
            foreach (tmp[i]) plan.push_back(tmp[i]);
            alu_hold = a_new;
        end
    endtask

    // Stimulus: replay the plan, pushing each cycle's expectation
    initial begin
        logic [5:0] ops [11];
        logic [5:0] op;
        int         pick;
        int         ab;
        ops = '{6'b100000, 6'b100011, 6'b101011, 6'b001000, 6'b000011, 6'b100110,
                6'b001110, 6'b000100, 6'b010000, 6'b000000, 6'b000010};
        bus.ins      = 32'h0;
        bus.memReady = 1'b0;
        alu_hold     = 5'd0;

        add_reset(3);
        add_instr(32'h80000000, 0, 0, -1);   // andr
        add_instr(32'h8C000000, 0, 3, -1);   // lw, slow memory
        add_instr(32'hAC000000, 0, 0, -1);   // sw
        add_instr(32'h0C000000, 0, 0, -1);   // jal
        add_instr(32'h40000000, 0, 0, -1);   // bleu
        add_instr(32'hFC000000, 0, 0, -1);   // illegal opcode
        add_instr(32'h8C001234, 0, 10, 5);   // lw aborted mid-wait in MEM
        add_instr(32'h80000000, 0, 0, -1);   // resume with andr
        add_instr(32'hAC000000, 0, 6, 4);    // sw aborted mid-wait in MEM
        add_instr(32'h8C000000, 6, 0, 3);    // aborted mid-wait in FETCH
        add_instr(32'h38000000, 2, 0, -1);   // nori

        for (int n = 0; n < 160; n++) begin
            pick = $urandom_range(0, 11);
            if (pick == 11) begin
                do op = 6'($urandom); while (kind_of(op) != "bad");
            end else begin
                op = ops[pick];
            end
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1;
            add_instr({op, 26'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3), ab);
        end

        while (plan.size() > 0) begin
            cyc_t c;
            c = plan.pop_front();
            @(posedge clk);
            #1;
            bus.ins      = c.ins;
            bus.memReady = c.rdy;
            reset        = c.rst;
            sb.push_back(c.expv);
            sb_tag.push_back(c.tag);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending entries, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: compare DUT outputs mid-cycle against the scoreboard head
    initial begin
        logic [19:0] e;
        logic [19:0] got;
        string       t;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                t   = sb_tag.pop_front();
                got = {bus.state, bus.ALUControl,
                       bus.illegal, bus.regWriteEnable, bus.jump, bus.branchEnable,
                       bus.ALUSrc, bus.regDst, bus.memToReg, bus.memWrite,
                       bus.pcWrite, bus.irWrite, bus.iorD, bus.memReq};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s cycle %0d got %h required %h", t, cycle_no, got, e);
                end
                cycle_no++;
            end
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL provide: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide: ins  in  32  instruction register contents; opcode = ins[31:26].
REQ-004 SHALL provide: memReady  in  1  memory completion for the current memReq.
REQ-005 SHALL provide: memReq  out  1  memory access request, held until memReady.
REQ-006 SHALL provide: iorD  out  1  0 = instruction address (PC), 1 = data address (ALU result).
REQ-007 SHALL provide: irWrite, pcWrite  out  1 each  load instruction register; load PC with PC+4.
REQ-008 SHALL provide: memWrite, memToReg, regDst, ALUSrc, branchEnable, jump, regWriteEnable  out  1 each  datapath controls.
REQ-009 SHALL provide: ALUControl  out  5  ALU operation, equal to latched ins[31:27].
REQ-010 SHALL provide: illegal  out  1  one-cycle pulse on an unrecognised opcode.
REQ-011 SHALL provide: state  out  3  current FSM state, for debug.

Function
REQ-012 Opcodes SHALL be decoded as: andr 100000, lw 100011, sw 101011, jr 001000, jal 000011, norr 100110, nori 001110, notr 000100, bleu 010000, rolv 000000, rorv 000010. R-class = andr, norr, nori, notr, rolv, rorv.
REQ-013 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 SHALL go to FETCH on the next edge.
REQ-014 FETCH: memReq=1 and iorD=0. While memReady=0 the FSM SHALL remain in FETCH. On memReady=1, irWrite=1 and pcWrite=1 in the same cycle, then the next state SHALL be DECODE.
REQ-015 DECODE: the opcode class and ins[31:27] SHALL be registered, and no datapath control is asserted. A legal opcode SHALL go to EXEC. An illegal opcode SHALL set illegal=1 for this cycle and go to FETCH.
REQ-016 EXEC: ALUControl = latched ins[31:27], and ALUSrc=1 for nori, lw and sw. Next state by class:
- R-class -> WB.
- lw, sw -> MEM.
- bleu: branchEnable=1 -> FETCH.
- jr: jump=1 -> FETCH.
- jal: jump=1 and regWriteEnable=1 -> FETCH.
REQ-017 MEM: memReq=1, iorD=1, memWrite=1 for sw only. The FSM SHALL hold while memReady=0. On memReady=1, lw SHALL go to WB and sw SHALL go to FETCH.
REQ-018 WB: regWriteEnable=1. R-class uses regDst=1, memToReg=0; lw uses regDst=0, memToReg=1. Next state SHALL be FETCH.
REQ-019 Every control not named for a state SHALL be 0 in that state; ALUControl SHALL hold the latched value outside EXEC.
REQ-020 memReady SHALL be ignored outside FETCH and MEM. A memReady arriving in the same cycle that memReq first rises SHALL complete the access.
REQ-021 With zero-wait memory, latency (including FETCH) SHALL be:
- R-class 4 cycles.
- lw 5 cycles.
- sw 4 cycles.
- bleu, jr, jal 3 cycles.
- illegal 2 cycles.
REQ-022 ins SHALL be sampled only in DECODE; changes to ins in other states SHALL have no effect.

Reset
REQ-023 While reset=1, state SHALL be FETCH, the latched opcode class SHALL be cleared (treated as illegal), and every output, including memReq, SHALL be 0.
REQ-024 Reset asserted in any state, including mid-wait in FETCH or MEM, SHALL abort the operation immediately with no write strobe completing.
REQ-025 On the first clk edge after reset deasserts, the FSM SHALL be in FETCH with memReq=1.

Structure
REQ-026 A shared package SHALL hold the opcode constants, the opcode-class enum, the state enum with the fixed encodings of REQ-013, and the ALU code width of 5.
REQ-027 Opcode classification SHALL live in one combinational sub-module, opcode_decode (ins[31:26] -> class, legal). The FSM and output logic SHALL live in multicycle_control.

Verification
REQ-028 andr (ins=0x80000000), memReady tied 1 -> states 0,1,2,4,0. WB: regWriteEnable=1, regDst=1. EXEC: ALUControl=5'b10000.
REQ-029 lw (0x8C000000), memReady delayed 3 cycles in MEM -> MEM lasts 4 cycles with memReq=1 and iorD=1, then WB with memToReg=1 and regWriteEnable=1.
REQ-030 sw (0xAC000000) -> MEM: memWrite=1 and ALUSrc=0. EXEC: ALUSrc=1. regWriteEnable never asserted; FSM returns to FETCH after MEM.
REQ-031 jal (0x0C000000) then bleu (0x40000000) -> jal EXEC: jump=1, regWriteEnable=1. bleu EXEC: branchEnable=1. Each takes 3 cycles.
REQ-032 Opcode 111111 -> illegal=1 for exactly one cycle in DECODE, then FETCH, with no write strobes.
REQ-033 Reset pulsed in MEM while memReady=0 -> all outputs 0 immediately; FETCH with memReq=1 one edge after release.
